// File: rtl/uart_verici.sv
// UART transmitter: bytes enter a small FIFO and leave as start, 8 data bits LSB first, then stop bits.
// Latency: tx_o falls one cycle after a byte is accepted while idle; hazir_o is low only while the FIFO is full.
module uart_verici #(
    parameter int FIFO_DERINLIK = 4,
    parameter int STOP_BIT      = 1
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [7:0]  gonderilecek_veri_i,
    input  logic        gonderilecek_gecerli_i,
    output logic        hazir_o,
    input  logic [15:0] baud_div_i,
    output logic        mesgul_o,
    output logic        tx_o
);
    localparam int AW = $clog2(FIFO_DERINLIK);
    localparam int CW = AW + 1;
    localparam logic STOP_SON = 1'(STOP_BIT - 1);

    typedef enum logic [1:0] {BOSTA, START, VERI, STOP} durum_t;

    logic [7:0]    mem_q [FIFO_DERINLIK];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    durum_t        state_q, state_d;
    logic [15:0]   baud_q, baud_d, cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          stop_cnt_q, stop_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d, mesgul_q, mesgul_d;
    logic          push, pop, fifo_bos, bit_son;

    assign hazir_o  = (count_q != CW'(FIFO_DERINLIK));
    assign mesgul_o = mesgul_q;
    assign tx_o     = tx_q;

    always_comb begin
        push       = gonderilecek_gecerli_i & hazir_o;
        pop        = 1'b0;
        fifo_bos   = (count_q == '0);
        bit_son    = (cnt_q == baud_q);
        state_d    = state_q;
        baud_d     = baud_q;
        cnt_d      = bit_son ? 16'd0 : cnt_q + 16'd1;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        case (state_q)
            BOSTA: begin
                tx_d  = 1'b1;
                cnt_d = 16'd0;
                if (!fifo_bos) begin
                    pop     = 1'b1;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_son) begin
                    state_d   = VERI;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end
            end
            VERI: begin
                if (bit_son) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d    = STOP;
                        stop_cnt_d = 1'b0;
                        tx_d       = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[bit_idx_q + 3'd1];
                    end
                end
            end
            STOP: begin
                if (bit_son) begin
                    if (stop_cnt_q == STOP_SON) begin
                        // Chain straight into the next start bit when more data is waiting.
                        if (!fifo_bos) begin
                            pop     = 1'b1;
                            state_d = START;
                            tx_d    = 1'b0;
                        end else begin
                            state_d = BOSTA;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = BOSTA;
        endcase

        // Frame start: load the head byte and freeze the bit period for the whole frame.
        if (pop) begin
            shift_d  = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + AW'(1);
            baud_d   = baud_div_i;
            cnt_d    = 16'd0;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        count_d  = count_q + CW'(push) - CW'(pop);
        mesgul_d = (state_d != BOSTA) || (count_d != '0);
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= gonderilecek_veri_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= BOSTA;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            baud_q     <= 16'd0;
            cnt_q      <= 16'd0;
            bit_idx_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            shift_q    <= 8'd0;
            tx_q       <= 1'b1;
            mesgul_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            baud_q     <= baud_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            mesgul_q   <= mesgul_d;
        end
    end
endmodule

// File: tb/tb_uart_verici.sv
// Bench for uart_verici: accepted bytes go to a scoreboard, a serial monitor decodes tx and compares.
module tb_uart_verici;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  veri = 8'd0, veri2 = 8'd0;
    logic        gecerli = 1'b0, gecerli2 = 1'b0;
    logic [15:0] baud = 16'd9;
    logic [15:0] baud2 = 16'd0;
    logic        hazir, mesgul, tx, hazir2, mesgul2, tx2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] q_exp[$];
    int acc_q[$];
    int start_q[$];

    uart_verici #(.FIFO_DERINLIK(4), .STOP_BIT(1)) dut (
        .clk_i(clk), .rstn_i(rst_n), .gonderilecek_veri_i(veri),
        .gonderilecek_gecerli_i(gecerli), .hazir_o(hazir), .baud_div_i(baud),
        .mesgul_o(mesgul), .tx_o(tx));

    uart_verici #(.FIFO_DERINLIK(4), .STOP_BIT(2)) dut2 (
        .clk_i(clk), .rstn_i(rst_n), .gonderilecek_veri_i(veri2),
        .gonderilecek_gecerli_i(gecerli2), .hazir_o(hazir2), .baud_div_i(baud2),
        .mesgul_o(mesgul2), .tx_o(tx2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [7:0] d);
        gecerli = 1'b1;
        veri    = d;
        step(1);
        gecerli = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int bound, output int n);
        n = 0;
        while (mesgul !== 1'b0 && n < bound) begin
            step(1);
            n++;
        end
        chk(nm, mesgul, 0);
    endtask

    // Inputs are driven just after posedge, so valid & hazir at negedge predicts the next edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && gecerli === 1'b1 && hazir === 1'b1) begin
            q_exp.push_back(veri);
            acc_q.push_back(cyc + 1);
        end
    end

    // Serial receiver: checks every cycle of the frame against the bit period latched at start.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                int bd, tot, pos, off;
                bit bad, abort;
                logic [7:0] rx;
                bd = int'(baud) + 1;
                tot = 10 * bd;
                bad = 1'b0;
                abort = 1'b0;
                rx = 8'd0;
                start_q.push_back(cyc);
                for (int i = 0; i < tot; i++) begin
                    if (i > 0) @(negedge clk);
                    if (rst_n !== 1'b1) begin
                        abort = 1'b1;
                        break;
                    end
                    pos = i / bd;
                    off = i % bd;
                    if (pos == 0) begin
                        if (tx !== 1'b0) bad = 1'b1;
                    end else if (pos == 9) begin
                        if (tx !== 1'b1) bad = 1'b1;
                    end else if (off == 0) begin
                        rx[pos-1] = tx;
                    end else if (tx !== rx[pos-1]) begin
                        bad = 1'b1;
                    end
                end
                if (!abort) begin
                    chk("frame_shape", 32'(bad), 0);
                    if (q_exp.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_unexpected actual=%0d required=none", rx);
                    end else begin
                        chk("rx_byte", 32'(rx), 32'(q_exp.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  veri;
        logic [15:0] baud;
        int          len;
    } vec_t;

    initial begin
        vec_t tbl[5];
        int n, base, k;
        bit seen, bad;
        logic [10:0] got;

        tbl[0] = '{8'hA5, 16'd9, 100};
        tbl[1] = '{8'h3C, 16'd1, 20};
        tbl[2] = '{8'h00, 16'd0, 10};
        tbl[3] = '{8'hFF, 16'd2, 30};
        tbl[4] = '{8'h81, 16'd4, 50};

        // Reset values
        step(3);
        chk("rst_tx", tx, 1);
        chk("rst_hazir", hazir, 1);
        chk("rst_mesgul", mesgul, 0);
        chk("rst_tx2", tx2, 1);
        chk("rst_mesgul2", mesgul2, 0);
        rst_n = 1'b1;
        step(2);

        // Single-byte frames: latency, length and idle edge of mesgul_o
        for (int r = 0; r < 5; r++) begin
            baud = tbl[r].baud;
            chk("t_hazir", hazir, 1);
            push1(tbl[r].veri);
            chk("t_mesgul_accept", mesgul, 1);
            chk("t_tx_idle_accept", tx, 1);
            step(1);
            chk("t_start_low", tx, 0);
            step(tbl[r].len - 1);
            chk("t_last_stop", tx, 1);
            chk("t_mesgul_last", mesgul, 1);
            step(1);
            chk("t_mesgul_drop", mesgul, 0);
            step(3);
        end

        // Back-to-back: three contiguous 40-cycle frames
        start_q.delete();
        baud = 16'd3;
        gecerli = 1'b1;
        veri = 8'h00;
        step(1);
        veri = 8'hFF;
        step(1);
        veri = 8'h55;
        step(1);
        gecerli = 1'b0;
        wait_idle("b_idle_timeout", 400, n);
        chk("b_frames", start_q.size(), 3);
        if (start_q.size() == 3) begin
            chk("b_gap01", start_q[1] - start_q[0], 40);
            chk("b_gap12", start_q[2] - start_q[1], 40);
        end
        step(3);

        // FIFO full with valid held high
        baud = 16'd15;
        base = acc_q.size();
        seen = 1'b0;
        gecerli = 1'b1;
        veri = 8'h10;
        k = 0;
        for (int c = 0; c < 400; c++) begin
            step(1);
            k = acc_q.size() - base;
            if (k >= 6) break;
            veri = 8'h10 + 8'(k * 17);
            if (k == 5 && !seen) begin
                chk("f_full_hazir", hazir, 0);
                seen = 1'b1;
            end
        end
        gecerli = 1'b0;
        chk("f_accepted", k, 6);
        chk("f_refull_hazir", hazir, 0);
        if (k == 6) begin
            chk("f_fill_time", acc_q[base+4] - acc_q[base], 4);
            chk("f_sixth_time", acc_q[base+5] - acc_q[base], 162);
        end
        wait_idle("f_idle_timeout", 1500, n);
        step(3);

        // Baud change during the data bits of frame one
        start_q.delete();
        baud = 16'd7;
        gecerli = 1'b1;
        veri = 8'h3C;
        step(1);
        veri = 8'hC3;
        step(1);
        gecerli = 1'b0;
        step(28);
        baud = 16'd3;
        wait_idle("c_idle_timeout", 400, n);
        chk("c_total", n, 92);
        chk("c_frames", start_q.size(), 2);
        if (start_q.size() == 2) chk("c_frame1_len", start_q[1] - start_q[0], 80);
        step(3);

        // STOP_BIT=2, baud 0, byte 0x81
        gecerli2 = 1'b1;
        veri2 = 8'h81;
        step(1);
        gecerli2 = 1'b0;
        got = '0;
        for (int i = 0; i < 11; i++) begin
            step(1);
            got[i] = tx2;
        end
        chk("s2_frame_bits", 32'(got), 32'(11'b111_0000_0010));
        chk("s2_mesgul_last", mesgul2, 1);
        step(1);
        chk("s2_mesgul_drop", mesgul2, 0);

        // Asynchronous reset in the middle of a low data bit
        baud = 16'd7;
        gecerli = 1'b1;
        veri = 8'h00;
        step(1);
        veri = 8'h77;
        step(1);
        gecerli = 1'b0;
        step(19);
        chk("r_pre_low", tx, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("r_tx_async", tx, 1);
        chk("r_hazir_async", hazir, 1);
        chk("r_mesgul_async", mesgul, 0);
        step(2);
        q_exp.delete();
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (tx !== 1'b1 || mesgul !== 1'b0) bad = 1'b1;
        end
        chk("r_no_resume", 32'(bad), 0);
        chk("sb_drained", q_exp.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
